sram_rw_ctrl: RTL and testbench

- Initiator for the 8x256 single-port SRAM macro: drives csb0/web0/addr0/din0 and captures dout0.
- Converts burst commands (start address + length) from the SPI slave datapath into per-beat SRAM accesses.
- Write data enters on a valid/ready stream; read data leaves on a valid/ready stream through a 3-entry read buffer.
- Sustains one beat per cycle in both directions.

---
 rtl/sram_rw_ctrl.sv | 125 ++++++++++++
 tb/tb_sram_rw_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/sram_rw_ctrl.sv
// sram_rw_ctrl: turns burst commands into per-beat accesses on a single-port SRAM,
// with a valid/ready write stream in and a 3-entry buffered read stream out.
module sram_rw_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_e;
    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d, addr_q, addr_d;
    logic [8:0]            left_q, left_d;
    logic                  csb_q, csb_d, web_q, web_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic [DATA_WIDTH-1:0] buf_q [3];
    logic [1:0]            cnt_q, wp_q, rp_q;
    logic                  p1, p2_q, pop;
    logic [2:0]            credit;

    // p1: read being driven this cycle; p2_q: read sampled last edge, data due next edge
    assign p1        = ~csb_q & web_q;
    assign pop       = rd_valid & rd_ready;
    assign credit    = {1'b0, cnt_q} + {2'b0, p1} + {2'b0, p2_q} - {2'b0, pop};
    assign cmd_ready = (state_q == IDLE) & ~rst;
    assign wr_ready  = state_q == WRITE;
    assign busy      = state_q != IDLE;
    assign rd_valid  = cnt_q != 2'd0;
    assign rd_data   = buf_q[rp_q];
    assign sram_csb0  = csb_q;
    assign sram_web0  = web_q;
    assign sram_addr0 = addr_q;
    assign sram_din0  = din_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        left_d  = left_q;
        csb_d   = 1'b1;
        web_d   = 1'b1;
        addr_d  = addr_q;
        din_d   = din_q;
        case (state_q)
            IDLE: if (cmd_valid) begin
                if (cmd_write) begin
                    state_d = WRITE;
                    ptr_d   = cmd_addr;
                    left_d  = {1'b0, cmd_len} + 9'd1;
                end else begin
                    // the buffer is always empty here, so the first read issues at once
                    csb_d   = 1'b0;
                    addr_d  = cmd_addr;
                    ptr_d   = cmd_addr + ADDR_WIDTH'(1);
                    left_d  = {1'b0, cmd_len};
                    state_d = (cmd_len == 8'd0) ? DRAIN : READ;
                end
            end
            WRITE: if (wr_valid) begin
                csb_d   = 1'b0;
                web_d   = 1'b0;
                addr_d  = ptr_q;
                din_d   = wr_data;
                ptr_d   = ptr_q + ADDR_WIDTH'(1);
                left_d  = left_q - 9'd1;
                state_d = (left_q == 9'd1) ? IDLE : WRITE;
            end
            READ: if (credit < 3'd3) begin
                csb_d   = 1'b0;
                addr_d  = ptr_q;
                ptr_d   = ptr_q + ADDR_WIDTH'(1);
                left_d  = left_q - 9'd1;
                state_d = (left_q == 9'd1) ? DRAIN : READ;
            end
            default: if (!p1 && !p2_q && (cnt_q == 2'd0 || (cnt_q == 2'd1 && pop)))
                state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            left_q  <= '0;
            csb_q   <= 1'b1;
            web_q   <= 1'b1;
            addr_q  <= '0;
            din_q   <= '0;
            p2_q    <= 1'b0;
            cnt_q   <= 2'd0;
            wp_q    <= 2'd0;
            rp_q    <= 2'd0;
            for (int i = 0; i < 3; i++) buf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            left_q  <= left_d;
            csb_q   <= csb_d;
            web_q   <= web_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            p2_q    <= p1;
            cnt_q   <= cnt_q + {1'b0, p2_q} - {1'b0, pop};
            if (p2_q) buf_q[wp_q] <= sram_dout0;
            wp_q    <= p2_q ? ((wp_q == 2'd2) ? 2'd0 : wp_q + 2'd1) : wp_q;
            rp_q    <= pop ? ((rp_q == 2'd2) ? 2'd0 : rp_q + 2'd1) : rp_q;
        end
    end
endmodule

// File: tb/tb_sram_rw_ctrl.sv
// tb_sram_rw_ctrl: directed bursts against a behavioural SRAM, with a read-data
// scoreboard and an access log checked after every burst.
module tb_sram_rw_ctrl;
    logic       clk = 1'b0, rst = 1'b1;
    logic       cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [7:0] cmd_addr = '0, cmd_len = '0;
    logic       wr_valid = 1'b0, wr_ready;
    logic [7:0] wr_data = '0;
    logic       rd_valid, rd_ready = 1'b0;
    logic [7:0] rd_data;
    logic       busy, sram_csb0, sram_web0;
    logic [7:0] sram_addr0, sram_din0, sram_dout0;

    sram_rw_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .busy(busy),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_addr0(sram_addr0),
        .sram_din0(sram_din0), .sram_dout0(sram_dout0)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0, cyc = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // SRAM: values seen mid-cycle are what it samples at the next edge; the
    // write commits / read data appears one negedge later, ahead of the capture edge.
    logic [7:0] mem [256];
    logic       pend = 1'b0, pend_we = 1'b0;
    logic [7:0] pend_a = '0, pend_d = '0;
    initial sram_dout0 = '0;
    always @(negedge clk) begin
        if (pend && pend_we) mem[pend_a] <= pend_d;
        if (pend && !pend_we) sram_dout0 <= mem[pend_a];
        pend    <= !sram_csb0;
        pend_we <= !sram_web0;
        pend_a  <= sram_addr0;
        pend_d  <= sram_din0;
    end

    typedef struct packed {logic we; logic [7:0] a; logic [7:0] d;} acc_t;
    acc_t       acc_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] ref_mem [256];
    logic [7:0] wd[$];
    bit         vpat[$];
    bit         rp[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    bit         seen_valid = 1'b0;
    int         npop = 0, nrd = 0, max_occ = 0, first_cyc = 0, last_cyc = 0, hs_cyc = 0;

    always @(negedge clk) begin
        if (!sram_csb0) begin
            acc_q.push_back({!sram_web0, sram_addr0, sram_din0});
            if (sram_web0) nrd++;
        end
        if (nrd - npop > max_occ) max_occ = nrd - npop;
        if (rd_valid && !seen_valid) begin
            seen_valid = 1'b1;
            first_cyc  = cyc;
        end
        if (rd_valid && rd_ready) begin
            check("rd_beat_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) check("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
            npop++;
            last_cyc = cyc;
        end
    end

    task automatic wr_burst(input logic [7:0] a, input int n);
        int i = 0, k = 0, bad = 0;
        acc_q.delete();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_len = 8'(n - 1);
        check("wr_cmd_ready", 32'(cmd_ready), 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        while (i < n && k < 2000) begin
            wr_valid = vpat[k % vpat.size()];
            wr_data  = wd[i];
            if (wr_valid) check("wr_ready", 32'(wr_ready), 1);
            @(posedge clk); #1;
            if (wr_valid) begin
                ref_mem[8'(a + 8'(i))] = wd[i];
                i++;
            end
            k++;
        end
        wr_valid = 1'b0;
        check("wr_busy_done", 32'(busy), 0);
        @(negedge clk); #1;
        check("wr_access_count", 32'(acc_q.size()), 32'(n));
        for (int j = 0; j < n && j < acc_q.size(); j++)
            if (acc_q[j] !== {1'b1, 8'(a + 8'(j)), wd[j]}) bad++;
        check("wr_access_content", 32'(bad), 0);
    endtask

    task automatic rd_start(input logic [7:0] a, input int n);
        acc_q.delete(); exp_q.delete();
        seen_valid = 1'b0; npop = 0; nrd = 0; max_occ = 0;
        for (int i = 0; i < n; i++) exp_q.push_back(ref_mem[8'(a + 8'(i))]);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = a; cmd_len = 8'(n - 1);
        check("rd_cmd_ready", 32'(cmd_ready), 1);
        @(posedge clk); #1;
        hs_cyc = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic rd_burst(input logic [7:0] a, input int n, input bit toggle);
        int k = 0, bad = 0;
        rd_ready = 1'b1;
        rd_start(a, n);
        while (npop < n && k < 3000) begin
            rd_ready = toggle ? rp[k % 4] : 1'b1;
            @(posedge clk); #1;
            k++;
        end
        rd_ready = 1'b0;
        check("rd_beats", 32'(npop), 32'(n));
        check("rd_latency", 32'(first_cyc - hs_cyc), 2);
        check("rd_busy_done", 32'(busy), 0);
        check("rd_valid_done", 32'(rd_valid), 0);
        check("rd_occupancy_le3", 32'(max_occ <= 3), 1);
        check("rd_access_count", 32'(acc_q.size()), 32'(n));
        for (int j = 0; j < n && j < acc_q.size(); j++)
            if (acc_q[j].we !== 1'b0 || acc_q[j].a !== 8'(a + 8'(j))) bad++;
        check("rd_access_addr", 32'(bad), 0);
        if (!toggle) check("rd_throughput", 32'(last_cyc - first_cyc), 32'(n - 1));
    endtask

    initial begin
        repeat (2) @(posedge clk); #1;
        check("rst_csb0", 32'(sram_csb0), 1);
        check("rst_web0", 32'(sram_web0), 1);
        check("rst_addr0", 32'(sram_addr0), 0);
        check("rst_din0", 32'(sram_din0), 0);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_wr_ready", 32'(wr_ready), 0);
        check("rst_cmd_ready", 32'(cmd_ready), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        wd = '{8'hA5}; vpat = '{1'b1};
        wr_burst(8'h10, 1);
        rd_burst(8'h10, 1, 1'b0);

        wd.delete();
        for (int i = 0; i < 256; i++) wd.push_back(8'(8'h37 + 8'(i)) ^ 8'h5A);
        wr_burst(8'h37, 256);
        rd_burst(8'h37, 256, 1'b0);

        wd = '{8'h11, 8'h22, 8'h33, 8'h44};
        wr_burst(8'hFE, 4);
        rd_burst(8'hFE, 4, 1'b0);

        wd = '{8'hC1, 8'hC2, 8'hC3}; vpat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        wr_burst(8'h40, 3);
        rd_burst(8'h40, 3, 1'b0);

        rd_burst(8'hFC, 8, 1'b1);

        rd_ready = 1'b1;
        rd_start(8'h20, 16);
        repeat (5) @(posedge clk); #1;
        rst = 1'b1; #1;
        check("abort_csb0", 32'(sram_csb0), 1);
        check("abort_rd_valid", 32'(rd_valid), 0);
        check("abort_busy", 32'(busy), 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort_cmd_ready", 32'(cmd_ready), 1);
        rd_burst(8'hFE, 4, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
